sht40_measure_sequencer: RTL
============================

Name: sht40_measure_sequencer

Overview:
- Sequences one SHT40 measurement over the shared byte-level I2C master:
  - write the measurement command byte;
  - wait the conversion time;
  - read 6 bytes;
  - CRC-check both words;
  - publish raw temperature and humidity.
- Sits between the processor-side control logic and the I2C master. It is the only requester that drives the master's transaction request inputs.

Parameters:
- SENSOR_ADDR, 7'h44, 7-bit I2C address of the SHT40.
- MEAS_CMD, 8'hFD, measurement command byte (high precision).
- WAIT_CYCLES, 200000, clk cycles between command write done and read start (10 ms at 20 MHz).
- MAX_RETRIES, 3, NACK retries per phase before an error is reported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- Meas_Start  in  1  one-cycle request to begin a measurement; ignored while Busy=1
- Busy  out  1  high from the accepted Meas_Start until Meas_Done
- Meas_Done  out  1  one-cycle pulse when a sequence ends (success or error)
- Temp_Raw  out  16  last good temperature word, MSB first
- Hum_Raw  out  16  last good humidity word, MSB first
- Data_Valid  out  1  high once a good measurement has been captured; sticky until reset
- Crc_Error  out  1  status of the last sequence: a CRC mismatch occurred
- Nack_Error  out  1  status of the last sequence: retries exhausted on NACK
- I2c_Req  out  1  one-cycle transaction request to the I2C master
- I2c_R_or_W  out  1  0 = write, 1 = read; held stable while a transaction is outstanding
- I2c_Address  out  7  equals SENSOR_ADDR
- I2c_Tx_Byte  out  8  write payload; equals MEAS_CMD
- I2c_Read_Count  out  4  bytes to read; 6 for read transactions, 0 for writes
- I2c_Rx_Valid  in  1  one-cycle strobe: I2c_Rx_Byte holds a received byte
- I2c_Rx_Byte  in  8  received byte
- I2c_Done  in  1  one-cycle pulse at the end of a transaction (after STOP)
- I2c_Nack  in  1  qualified by I2c_Done: the transaction was NACKed

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - Busy, Meas_Done, I2c_Req, I2c_R_or_W, Data_Valid, Crc_Error, Nack_Error all 0.
  - Temp_Raw and Hum_Raw 0; I2c_Read_Count 0.
  - State IDLE; retry counter, byte counter and wait counter all 0.
- States:
  - IDLE: on Meas_Start, clear Crc_Error and Nack_Error, set Busy, go to CMD_REQ.
  - CMD_REQ: drive I2c_Req=1 for exactly one cycle with R_or_W=0 and Tx_Byte=MEAS_CMD; go to CMD_WAIT.
  - CMD_WAIT: on I2c_Done with I2c_Nack=0, zero the wait counter and go to DELAY. On I2c_Done with I2c_Nack=1: if retries < MAX_RETRIES, increment the retry counter and return to CMD_REQ; otherwise go to FAIL_NACK.
  - DELAY: increment the counter each cycle. When the counter reaches WAIT_CYCLES-1, zero the retry and byte counters and go to RD_REQ. The first read request therefore occurs WAIT_CYCLES+1 cycles after the command I2c_Done.
  - RD_REQ: drive I2c_Req=1 for exactly one cycle with R_or_W=1 and Read_Count=6; go to RD_WAIT.
  - RD_WAIT:
    - Each I2c_Rx_Valid stores the byte into slot byte_cnt and increments byte_cnt; strobes beyond 6 are ignored.
    - On I2c_Done with NACK: clear byte_cnt, then retry via RD_REQ (same limit as CMD_WAIT) or go to FAIL_NACK.
    - On I2c_Done without NACK: if byte_cnt != 6, treat it as a NACK; otherwise go to CHECK.
  - CHECK (1 cycle):
    - CRC-8, polynomial 0x31, init 0xFF, no reflection, no final XOR.
    - Computed over bytes {0,1} and compared with byte 2; over {3,4} and compared with byte 5.
    - Both match: Temp_Raw={b0,b1}, Hum_Raw={b3,b4}, Data_Valid=1.
    - Any mismatch: Crc_Error=1; Temp_Raw and Hum_Raw unchanged.
    - Go to FINISH.
  - FAIL_NACK: Nack_Error=1; go to FINISH.
  - FINISH: Meas_Done=1 for one cycle, Busy=0, return to IDLE.
- The retry counter covers 2 bits or more and resets on each phase entry.
- Meas_Start while Busy=1 is dropped; requests are not queued.
- I2c_Done, I2c_Rx_Valid or I2c_Nack arriving in IDLE, DELAY or CHECK are ignored.
- If I2c_Rx_Valid and I2c_Done coincide, the byte is stored first, then byte_cnt is evaluated including that byte.
- rst_n asserted mid-sequence returns immediately to reset values. The I2C master is reset by the same rst_n.

Test Plan:
- Nominal: pulse Meas_Start; the master ACKs the write, then returns bytes 0xBE,0xEF,0x92,0x66,0x66,0x93. Required: one write request with Tx_Byte=0xFD, then a read request with Read_Count=6 exactly WAIT_CYCLES+1 cycles after the write Done. Temp_Raw=0xBEEF, Hum_Raw=0x6666, Data_Valid=1, both error flags 0, one Meas_Done pulse.
- CRC fail: same as nominal but byte 2 = 0x93. Required: Crc_Error=1; Temp_Raw and Hum_Raw keep their previous values; Meas_Done pulses; Busy falls.
- NACK retry: NACK the write twice, then ACK (MAX_RETRIES=3). Required: 3 write requests, then normal completion with Nack_Error=0.
- NACK exhaust: NACK every write. Required: 4 write requests, no read request, Nack_Error=1, Meas_Done pulse.
- Short read and busy guard:
  - I2c_Done after only 4 Rx_Valid strobes is treated as a NACK and triggers a read retry.
  - A Meas_Start pulsed during DELAY is ignored: exactly one Meas_Done results.
- Reset mid-DELAY: assert rst_n=0 for 1 cycle. Required: all outputs return to reset values immediately; the next Meas_Start runs a full sequence.

Source files
------------

// File: rtl/sht40_measure_sequencer_if.sv
// Byte-level I2C master request/response bundle shared by the SHT40 sequencer.
// The master modport is the requester side; slave is the I2C master engine.
interface sht40_measure_sequencer_if;
  logic       I2c_Req;
  logic       I2c_R_or_W;
  logic [6:0] I2c_Address;
  logic [7:0] I2c_Tx_Byte;
  logic [3:0] I2c_Read_Count;
  logic       I2c_Rx_Valid;
  logic [7:0] I2c_Rx_Byte;
  logic       I2c_Done;
  logic       I2c_Nack;

  modport master (
    output I2c_Req, I2c_R_or_W, I2c_Address, I2c_Tx_Byte, I2c_Read_Count,
    input  I2c_Rx_Valid, I2c_Rx_Byte, I2c_Done, I2c_Nack
  );

  modport slave (
    input  I2c_Req, I2c_R_or_W, I2c_Address, I2c_Tx_Byte, I2c_Read_Count,
    output I2c_Rx_Valid, I2c_Rx_Byte, I2c_Done, I2c_Nack
  );
endinterface

// File: rtl/sht40_measure_sequencer.sv
// Runs one SHT40 measurement: command write, conversion wait, 6-byte read,
// CRC-8 check of both words, then publishes raw temperature and humidity.
module sht40_measure_sequencer #(
  parameter logic [6:0]  SENSOR_ADDR = 7'h44,
  parameter logic [7:0]  MEAS_CMD    = 8'hFD,
  parameter int unsigned WAIT_CYCLES = 200000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Meas_Start,
  output logic        Busy,
  output logic        Meas_Done,
  output logic [15:0] Temp_Raw,
  output logic [15:0] Hum_Raw,
  output logic        Data_Valid,
  output logic        Crc_Error,
  output logic        Nack_Error,
  sht40_measure_sequencer_if.master i2c
);

  localparam int unsigned RetryBits = $clog2(MAX_RETRIES + 1);
  localparam int unsigned RetryW    = (RetryBits < 2) ? 2 : RetryBits;
  localparam int unsigned WaitW     = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [3:0] {
    StIdle, StCmdReq, StCmdWait, StDelay, StRdReq, StRdWait, StCheck, StFailNack, StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [5:0][7:0]   rx_q, rx_d;
  logic              rnw_q, rnw_d;
  logic [15:0]       temp_q, temp_d, hum_q, hum_d;
  logic              valid_q, valid_d, crc_err_q, crc_err_d, nack_err_q, nack_err_d;
  logic [2:0]        cnt_eff;
  logic              retry_ok;

  // CRC-8, poly 0x31, init 0xFF, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] data);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data[i]) ? 8'h31 : 8'h00);
    end
    return c;
  endfunction

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    byte_cnt_d = byte_cnt_q;
    wait_d     = wait_q;
    rx_d       = rx_q;
    rnw_d      = rnw_q;
    temp_d     = temp_q;
    hum_d      = hum_q;
    valid_d    = valid_q;
    crc_err_d  = crc_err_q;
    nack_err_d = nack_err_q;
    cnt_eff    = byte_cnt_q;
    retry_ok   = retry_q < RetryW'(MAX_RETRIES);

    case (state_q)
      StIdle: begin
        if (Meas_Start) begin
          crc_err_d  = 1'b0;
          nack_err_d = 1'b0;
          retry_d    = '0;
          rnw_d      = 1'b0;
          state_d    = StCmdReq;
        end
      end
      StCmdReq: state_d = StCmdWait;
      StCmdWait: begin
        if (i2c.I2c_Done) begin
          if (!i2c.I2c_Nack) begin
            wait_d  = '0;
            state_d = StDelay;
          end else if (retry_ok) begin
            retry_d = retry_q + 1'b1;
            state_d = StCmdReq;
          end else begin
            state_d = StFailNack;
          end
        end
      end
      StDelay: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == WaitW'(WAIT_CYCLES - 1)) begin
          retry_d    = '0;
          byte_cnt_d = '0;
          rnw_d      = 1'b1;
          state_d    = StRdReq;
        end
      end
      StRdReq: state_d = StRdWait;
      StRdWait: begin
        // A byte coinciding with Done is stored before the count is judged.
        if (i2c.I2c_Rx_Valid && (byte_cnt_q < 3'd6)) begin
          rx_d[byte_cnt_q] = i2c.I2c_Rx_Byte;
          cnt_eff          = byte_cnt_q + 3'd1;
        end
        byte_cnt_d = cnt_eff;
        if (i2c.I2c_Done) begin
          if (!i2c.I2c_Nack && (cnt_eff == 3'd6)) begin
            state_d = StCheck;
          end else begin
            byte_cnt_d = '0;
            if (retry_ok) begin
              retry_d = retry_q + 1'b1;
              state_d = StRdReq;
            end else begin
              state_d = StFailNack;
            end
          end
        end
      end
      StCheck: begin
        if ((crc8({rx_q[0], rx_q[1]}) == rx_q[2]) && (crc8({rx_q[3], rx_q[4]}) == rx_q[5])) begin
          temp_d  = {rx_q[0], rx_q[1]};
          hum_d   = {rx_q[3], rx_q[4]};
          valid_d = 1'b1;
        end else begin
          crc_err_d = 1'b1;
        end
        state_d = StFinish;
      end
      StFailNack: begin
        nack_err_d = 1'b1;
        state_d    = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      retry_q    <= '0;
      byte_cnt_q <= '0;
      wait_q     <= '0;
      rx_q       <= '0;
      rnw_q      <= 1'b0;
      temp_q     <= '0;
      hum_q      <= '0;
      valid_q    <= 1'b0;
      crc_err_q  <= 1'b0;
      nack_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      byte_cnt_q <= byte_cnt_d;
      wait_q     <= wait_d;
      rx_q       <= rx_d;
      rnw_q      <= rnw_d;
      temp_q     <= temp_d;
      hum_q      <= hum_d;
      valid_q    <= valid_d;
      crc_err_q  <= crc_err_d;
      nack_err_q <= nack_err_d;
    end
  end

  assign Busy               = (state_q != StIdle);
  assign Meas_Done          = (state_q == StFinish);
  assign Temp_Raw           = temp_q;
  assign Hum_Raw            = hum_q;
  assign Data_Valid         = valid_q;
  assign Crc_Error          = crc_err_q;
  assign Nack_Error         = nack_err_q;
  assign i2c.I2c_Req        = (state_q == StCmdReq) || (state_q == StRdReq);
  assign i2c.I2c_R_or_W     = rnw_q;
  assign i2c.I2c_Address    = SENSOR_ADDR;
  assign i2c.I2c_Tx_Byte    = MEAS_CMD;
  assign i2c.I2c_Read_Count = rnw_q ? 4'd6 : 4'd0;

endmodule
